// File: rtl/fetch_unit_pipelined_if.sv
// Bundle of all non-clock/reset signals of the fetch unit.
//   master : the fetch unit side (drives the imem request and the decode-side
//            instruction, receives redirect, imem ready/response and decode ready)
//   slave  : the environment side (branch unit, instruction memory, decode)
// Signals:
//   i_redirect_valid / i_redirect_addr   branch redirect request and target
//   o_imem_req_valid / o_imem_req_addr   imem request
//   i_imem_req_ready                     imem accepts request
//   i_imem_rsp_valid / i_imem_rsp_data   in-order imem response, no back-pressure
//   o_valid / o_instruction / o_pc / o_pc_plus4   head of instruction buffer
//   i_ready                              decode accepts head
interface fetch_unit_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_redirect_valid;
  logic [ADDR_WIDTH-1:0] i_redirect_addr;
  logic                  o_imem_req_valid;
  logic [ADDR_WIDTH-1:0] o_imem_req_addr;
  logic                  i_imem_req_ready;
  logic                  i_imem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_imem_rsp_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_instruction;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic [ADDR_WIDTH-1:0] o_pc_plus4;
  logic                  i_ready;

  modport master (
    input  i_redirect_valid, i_redirect_addr, i_imem_req_ready,
           i_imem_rsp_valid, i_imem_rsp_data, i_ready,
    output o_imem_req_valid, o_imem_req_addr, o_valid, o_instruction,
           o_pc, o_pc_plus4
  );

  modport slave (
    output i_redirect_valid, i_redirect_addr, i_imem_req_ready,
           i_imem_rsp_valid, i_imem_rsp_data, i_ready,
    input  o_imem_req_valid, o_imem_req_addr, o_valid, o_instruction,
           o_pc, o_pc_plus4
  );
endinterface

// File: rtl/fetch_unit_pipelined.sv
// Pipelined instruction fetch stage.
// Issues in-order imem requests (several may be in flight), buffers the
// returned words in a FIFO tagged with their PC and hands them to decode over
// a valid/ready handshake. A redirect flushes the buffer, restarts fetch at
// the (word-aligned) target and discards every response still in flight.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    fetch_unit_pipelined_if.master: redirect, imem request/response,
//          decode-side instruction handshake
module fetch_unit_pipelined #(
  parameter int                  DATA_WIDTH      = 32,
  parameter int                  ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
  parameter int                  FIFO_DEPTH      = 4,
  parameter int                  MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  fetch_unit_pipelined_if.master  bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = CW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         drop;
  logic [OW-1:0]         live;
  logic [CW-1:0]         count;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  logic [ADDR_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];

  logic                  req_valid;
  logic                  req_hs;
  logic                  rsp_acc;
  logic                  push;
  logic                  pop;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] pc_tag;
  logic                  space_ok;
  logic                  out_ok;

  // Target low bits are forced to zero, so they are intentionally not used.
  wire unused_redirect_lsbs = &{1'b0, bus.i_redirect_addr[1:0]};

  always_comb begin
    live     = outstanding - drop;
    // Every live request already owns a FIFO slot; a new one needs a free slot.
    space_ok = ({1'b0, count} + SW'(live)) < SW'(FIFO_DEPTH);
    out_ok   = outstanding < OW'(MAX_OUTSTANDING);
    req_valid = !reset && !bus.i_redirect_valid && out_ok && space_ok;
    req_hs    = req_valid && bus.i_imem_req_ready;
    // A response with nothing outstanding is a protocol violation; ignore it
    // rather than wrap the counters.
    rsp_acc   = bus.i_imem_rsp_valid && (outstanding != '0);
    push      = rsp_acc && (drop == '0) && !bus.i_redirect_valid;
    out_valid = (count != '0) && !bus.i_redirect_valid;
    pop       = out_valid && bus.i_ready;
    // Oldest live request: fetch_pc has advanced 4 bytes per live request.
    pc_tag    = fetch_pc - (ADDR_WIDTH'(live) << 2);
  end

  assign bus.o_imem_req_valid = req_valid;
  assign bus.o_imem_req_addr  = fetch_pc;
  assign bus.o_valid          = out_valid;
  assign bus.o_instruction    = fifo_instr[head];
  assign bus.o_pc             = fifo_pc[head];
  assign bus.o_pc_plus4       = fifo_pc[head] + ADDR_WIDTH'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (bus.i_redirect_valid) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc    <= {bus.i_redirect_addr[ADDR_WIDTH-1:2], 2'b00};
      outstanding <= outstanding - OW'(rsp_acc);
      drop        <= outstanding - OW'(rsp_acc);
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      if (req_hs) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      outstanding <= outstanding + OW'(req_hs) - OW'(rsp_acc);
      if (rsp_acc && (drop != '0)) begin
        drop <= drop - OW'(1);
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]    <= pc_tag;
      fifo_instr[tail] <= bus.i_imem_rsp_data;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (count < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_unit_pipelined.sv
module tb_fetch_unit_pipelined;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus  ();
  fetch_unit_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

  fetch_unit_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(MAXO)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  fetch_unit_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(MAXO)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Memory model: in-order queue of accepted addresses with their due cycle.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // Program-order reference: decode must see exp_pc, exp_pc+4, ... since the
  // last reset/redirect, and requests must walk the same sequence.
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          hs_cnt;
  int          pop_cnt;
  logic [31:0] first_pc;
  logic        prev_pend;
  logic [31:0] prev_addr;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic        s_rsp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic cycle(input logic redir, input logic [31:0] raddr,
                       input logic rq_rdy, input logic dec_rdy);
    int occ;
    int due;
    @(negedge clk);
    bus.i_redirect_valid = redir;
    bus.i_redirect_addr  = raddr;
    bus.i_imem_req_ready = rq_rdy;
    bus.i_ready          = dec_rdy;
    occ = mq_due.size();
    if (occ > 0 && mq_due[0] <= cyc) begin
      bus.i_imem_rsp_valid = 1'b1;
      bus.i_imem_rsp_data  = mem_word(mq_addr[0]);
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
      s_rsp = 1'b1;
    end else begin
      bus.i_imem_rsp_valid = 1'b0;
      bus.i_imem_rsp_data  = $urandom;
      s_rsp = 1'b0;
    end
    #1;
    s_req_valid = bus.o_imem_req_valid;
    s_req_addr  = bus.o_imem_req_addr;
    s_valid     = bus.o_valid;
    s_pc        = bus.o_pc;
    if (redir) begin
      tests++;
      if (bus.o_valid !== 1'b0 || bus.o_imem_req_valid !== 1'b0) begin
        fails++;
        $display("FAIL redirect_mask cyc=%0d: o_valid=%b req_valid=%b, required 0/0",
                 cyc, bus.o_valid, bus.o_imem_req_valid);
      end
    end
    if (prev_pend && !redir) begin
      tests++;
      if (bus.o_imem_req_valid !== 1'b1 || bus.o_imem_req_addr !== prev_addr) begin
        fails++;
        $display("FAIL req_stable cyc=%0d: valid=%b addr=%h, required 1 addr=%h",
                 cyc, bus.o_imem_req_valid, bus.o_imem_req_addr, prev_addr);
      end
    end
    if (bus.o_imem_req_valid === 1'b1) begin
      tests++;
      if (bus.o_imem_req_addr !== exp_req) begin
        fails++;
        $display("FAIL req_addr cyc=%0d: got %h, required %h", cyc, bus.o_imem_req_addr, exp_req);
      end
      if (rq_rdy) begin
        tests++;
        if (occ >= MAXO) begin
          fails++;
          $display("FAIL max_outstanding cyc=%0d: request with %0d in flight, limit %0d",
                   cyc, occ, MAXO);
        end
        due = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_addr.push_back(bus.o_imem_req_addr);
        mq_due.push_back(due);
        exp_req = exp_req + 32'd4;
        hs_cnt++;
      end
    end
    prev_pend = bus.o_imem_req_valid && !rq_rdy;
    prev_addr = bus.o_imem_req_addr;
    if (bus.o_valid === 1'b1 && dec_rdy) begin
      tests++;
      if (bus.o_pc !== exp_pc || bus.o_instruction !== mem_word(exp_pc) ||
          bus.o_pc_plus4 !== exp_pc + 32'd4) begin
        fails++;
        $display("FAIL decode cyc=%0d: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                 cyc, bus.o_pc, bus.o_instruction, bus.o_pc_plus4,
                 exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
      end
      if (pop_cnt == 0) first_pc = bus.o_pc;
      exp_pc = exp_pc + 32'd4;
      pop_cnt++;
    end
    if (redir) begin
      exp_pc  = {raddr[31:2], 2'b00};
      exp_req = {raddr[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drive_idle();
    bus.i_redirect_valid  = 1'b0; bus.i_redirect_addr = '0;
    bus.i_imem_req_ready  = 1'b0; bus.i_imem_rsp_valid = 1'b0;
    bus.i_imem_rsp_data   = '0;   bus.i_ready = 1'b0;
    bus2.i_redirect_valid = 1'b0; bus2.i_redirect_addr = '0;
    bus2.i_imem_req_ready = 1'b0; bus2.i_imem_rsp_valid = 1'b0;
    bus2.i_imem_rsp_data  = '0;   bus2.i_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    mq_addr.delete();
    mq_due.delete();
    last_due  = cyc;
    exp_pc    = 32'h0;
    exp_req   = 32'h0;
    hs_cnt    = 0;
    pop_cnt   = 0;
    prev_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.o_imem_req_valid !== 1'b0 || bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_valids: req_valid=%b o_valid=%b, required 0/0",
               bus.o_imem_req_valid, bus.o_valid);
    end
    tests++;
    if (bus.o_imem_req_addr !== 32'h0) begin
      fails++;
      $display("FAIL async_reset_addr: got %h, required 00000000", bus.o_imem_req_addr);
    end
    tests++;
    if (bus2.o_imem_req_addr !== 32'hFFFF_FFF8 || bus2.o_imem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_pc_param: addr=%h valid=%b, required fffffff8/0",
               bus2.o_imem_req_addr, bus2.o_imem_req_valid);
    end
    do_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (s_req_valid !== 1'b1 || s_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_cycle: req_valid=%b o_valid=%b, required 1/0", s_req_valid, s_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (hs_cnt != 20) begin
      fails++;
      $display("FAIL stream_requests: got %0d, required 20", hs_cnt);
    end
    tests++;
    if (pop_cnt != 18) begin
      fails++;
      $display("FAIL stream_throughput: got %0d pops, required 18", pop_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (hs_cnt != 4) begin
      fails++;
      $display("FAIL stall_requests: got %0d, required 4", hs_cnt);
    end
    tests++;
    if (s_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_req_off: req_valid=%b, required 0", s_req_valid);
    end
    tests++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      fails++;
      $display("FAIL stall_head: o_valid=%b o_pc=%h, required 1/00000000", s_valid, s_pc);
    end
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (pop_cnt != 10) begin
      fails++;
      $display("FAIL stall_resume: got %0d pops, required 10", pop_cnt);
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (3) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      tests++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
        fails++;
        $display("FAIL req_hold: valid=%b addr=%h, required 1/00000000", s_req_valid, s_req_addr);
      end
    end
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (hs_cnt != 6 || pop_cnt != 4) begin
      fails++;
      $display("FAIL req_release: requests=%0d pops=%0d, required 6/4", hs_cnt, pop_cnt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    pop_cnt = 0;
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    repeat (14) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (pop_cnt < 3 || first_pc !== 32'h0000_0100) begin
      fails++;
      $display("FAIL redirect_target: pops=%0d first_pc=%h, required >=3 and 00000100",
               pop_cnt, first_pc);
    end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    pop_cnt = 0;
    cycle(1'b1, 32'h0000_0202, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_0200) begin
      fails++;
      $display("FAIL redirect_next_req: valid=%b addr=%h, required 1/00000200",
               s_req_valid, s_req_addr);
    end
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (pop_cnt != 7 || first_pc !== 32'h0000_0200) begin
      fails++;
      $display("FAIL redirect_rsp_drop: pops=%0d first_pc=%h, required 7/00000200",
               pop_cnt, first_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1400; i++) begin
      if (i == 600) do_reset();
      tgt = $urandom;
      if ((i % 97) == 5) tgt = 32'hFFFF_FFF5;
      cycle(($urandom % 16) == 0, tgt, ($urandom % 10) < 7, ($urandom % 10) < 6);
    end
    tests++;
    if (pop_cnt <= 20) begin
      fails++;
      $display("FAIL random_progress: got %0d pops, required >20", pop_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs[$];
    logic [31:0] pcs[$];
    logic [31:0] p4s[$];
    logic [31:0] ins[$];
    logic        pend;
    logic [31:0] pend_addr;
    do_reset();
    pend = 1'b0;
    pend_addr = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus2.i_imem_req_ready = 1'b1;
      bus2.i_ready          = 1'b1;
      bus2.i_imem_rsp_valid = pend;
      bus2.i_imem_rsp_data  = mem_word(pend_addr);
      #1;
      if (bus2.o_valid === 1'b1) begin
        pcs.push_back(bus2.o_pc);
        p4s.push_back(bus2.o_pc_plus4);
        ins.push_back(bus2.o_instruction);
      end
      pend = (bus2.o_imem_req_valid === 1'b1);
      pend_addr = bus2.o_imem_req_addr;
      if (pend) reqs.push_back(bus2.o_imem_req_addr);
      @(posedge clk);
    end
    tests++;
    if (reqs.size() < 3) begin
      fails++;
      $display("FAIL wrap_req_count: got %0d, required >=3", reqs.size());
    end else if (reqs[0] !== 32'hFFFF_FFF8 || reqs[1] !== 32'hFFFF_FFFC || reqs[2] !== 32'h0) begin
      fails++;
      $display("FAIL wrap_req_addrs: got %h %h %h, required fffffff8 fffffffc 00000000",
               reqs[0], reqs[1], reqs[2]);
    end
    tests++;
    if (pcs.size() < 3) begin
      fails++;
      $display("FAIL wrap_pop_count: got %0d, required >=3", pcs.size());
    end else if (pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0 ||
                 p4s[1] !== 32'h0 || ins[1] !== mem_word(32'hFFFF_FFFC)) begin
      fails++;
      $display("FAIL wrap_decode: pcs %h %h %h pc4[1]=%h instr[1]=%h, required fffffff8 fffffffc 00000000 pc4 00000000 instr %h",
               pcs[0], pcs[1], pcs[2], p4s[1], ins[1], mem_word(32'hFFFF_FFFC));
    end
    drive_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_stream();
    test_stall();
    test_req_stall();
    test_redirect();
    test_redirect_rsp();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit_pipelined.md
Name: fetch_unit_pipelined

Overview:
Parametrised fetch stage that drives a pipelined, in-order instruction-memory request/response interface, buffers returned instructions in a FIFO, and presents them to decode over a valid/ready handshake. It supports multiple outstanding requests, back-pressure from decode, and branch redirect with flush. In-flight responses fetched before a redirect are discarded.

Parameters:
DATA_WIDTH, 32, instruction width
ADDR_WIDTH, 32, PC / address width
RESET_PC, 0, PC value loaded on reset
FIFO_DEPTH, 4, instruction buffer entries; power of 2, >=2
MAX_OUTSTANDING, 2, max in-flight imem requests; 1..FIFO_DEPTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_redirect_valid  in  1  branch taken / redirect request
i_redirect_addr  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
o_imem_req_valid  out  1  request valid
o_imem_req_addr  out  ADDR_WIDTH  request address
i_imem_req_ready  in  1  memory accepts request
i_imem_rsp_valid  in  1  response valid (in order, no back-pressure)
i_imem_rsp_data  in  DATA_WIDTH  instruction word
o_valid  out  1  instruction available to decode
o_instruction  out  DATA_WIDTH  head instruction
o_pc  out  ADDR_WIDTH  address of head instruction
o_pc_plus4  out  ADDR_WIDTH  o_pc + 4, modulo 2^ADDR_WIDTH
i_ready  in  1  decode accepts head

Behaviour:
- Reset, async: fetch_pc=RESET_PC; outstanding=0; drop=0; FIFO empty; o_valid=0; o_imem_req_valid=0 while reset is high. o_imem_req_addr=RESET_PC.
- State: fetch_pc; outstanding counter and drop counter, each $clog2(MAX_OUTSTANDING+1) bits; FIFO of {pc, instr} with count $clog2(FIFO_DEPTH+1) bits.
- live = outstanding - drop.
- Request: o_imem_req_valid = !i_redirect_valid && outstanding<MAX_OUTSTANDING && live+count<FIFO_DEPTH. o_imem_req_addr=fetch_pc.
- On req handshake: fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH; outstanding increments.
- Request stability: once o_imem_req_valid is high, it stays high with a stable address until ready. The only exception is a redirect, which withdraws the request.
- Response: outstanding decrements.
  - If drop>0: discard the response and decrement drop.
  - Else: push {pc tag, data} into the FIFO. The pc tag comes from an internal issued-PC queue, or equivalently fetch_pc - 4*live.
- Each imem request is issued only when FIFO space is reserved, so a push never overflows. Overflow is an assertion failure.
- Simultaneous req handshake and response in one cycle: outstanding is unchanged.
- Decode side: o_valid = count>0 && !i_redirect_valid. Head fields are driven from FIFO[head]. Pop on o_valid && i_ready.
- Push and pop in the same cycle: count is unchanged. Push into an empty FIFO is visible on o_valid the next cycle (1-cycle response-to-decode latency).
- Redirect cycle, highest priority:
  - No request is issued.
  - No pop occurs (o_valid is masked).
  - Any response in that cycle is discarded.
  - Next cycle: FIFO emptied; fetch_pc = {i_redirect_addr[ADDR_WIDTH-1:2], 2'b00}; drop = outstanding - (i_imem_rsp_valid ? 1 : 0); outstanding decremented accordingly.
  - First request to the new target is presented the cycle after the redirect.
- Back-to-back redirects: the last one wins. Drop accumulates correctly because no requests issue during redirect cycles.
- Decode stall (i_ready=0): head is held stable. Requests continue until live+count reaches FIFO_DEPTH, then stop.
- Reset asserted mid-operation: immediate return to the reset state. Any responses arriving after reset deasserts with outstanding=0 are a protocol violation and are not handled.

Test Plan:
- Reset release, i_imem_req_ready=1, 1-cycle response latency, i_ready=1: req addrs 0,4,8,... every cycle -> o_pc sequence 0,4,8 with o_pc_plus4 4,8,12; steady state of one instruction per cycle.
- i_ready=0 for 10 cycles, FIFO_DEPTH=4: exactly 4 requests issued (addrs 0..12); o_imem_req_valid low afterwards; o_pc held at 0. Releasing i_ready -> 0,4,8,12 then fetch resumes at 16.
- Redirect to 0x103 while 2 requests are outstanding: both responses dropped; next request addr 0x100; first o_pc after the redirect is 0x100. No stale PC ever appears on decode.
- Redirect in the same cycle as a response and a pending pop: response dropped, no pop, drop=outstanding-1; o_valid low that cycle.
- i_imem_req_ready held low 3 cycles with req pending: o_imem_req_addr stable; fetch_pc does not advance.
- RESET_PC=0xFFFFFFF8 (ADDR_WIDTH=32): requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0; o_pc_plus4 of 0xFFFFFFFC equals 0x0.
